regfile_wr_arbiter: RTL and testbench

- Shares the single register-file write port between two sources:
  - the in-order pipeline write-back result;
  - a long-latency unit (multi-cycle mul/div or slow load return).
- Sits between the write-back stage and the register file.
- Buffers long-latency results in a small FIFO and stalls the pipeline only when a buffered result must take the port.
- Resolves WAW ordering and bounds starvation of buffered results.

---
 rtl/regfile_wr_arbiter_pkg.sv | 19 +
 rtl/regfile_wr_arbiter_fifo.sv | 67 ++++++
 rtl/regfile_wr_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared register-file write types: widths and the write-back request record.
package regfile_wr_arbiter_pkg;

  localparam int REG_ID_W = 5;
  localparam int XLEN     = 32;
  localparam int ENTRY_W  = REG_ID_W + XLEN;

  typedef struct packed {
    logic                en;
    logic [REG_ID_W-1:0] rd_id;
    logic [XLEN-1:0]     data;
  } wb_req_t;

  typedef struct packed {
    logic [REG_ID_W-1:0] rd_id;
    logic [XLEN-1:0]     data;
  } lu_entry_t;

endpackage

// File: rtl/regfile_wr_arbiter_fifo.sv
// Small sync FIFO for long-latency results; exposes per-slot rd/valid so the
// parent can build a busy mask. Push is refused when full, even alongside a pop.
module regfile_wr_arbiter_fifo
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  lu_entry_t                       push_entry,
  input  logic                            pop,
  output logic                            full,
  output logic                            empty,
  output lu_entry_t                       head,
  output logic [DEPTH-1:0]                entry_vld,
  output logic [DEPTH-1:0][REG_ID_W-1:0]  entry_rd
);

  localparam int AW = $clog2(DEPTH);

  lu_entry_t     mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; validity comes only from the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_comb begin
    logic [AW-1:0] off;
    entry_vld = '0;
    entry_rd  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = AW'(i) - rd_ptr;
      entry_vld[i] = ((AW+1)'(off) < count);
      entry_rd[i]  = mem[i].rd_id;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single register-file write port between pipeline write-back
// and buffered long-latency results, enforcing WAW order and bounded starvation.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pipe_wr_en_i,
  input  logic [REG_ID_W-1:0] pipe_rd_id_i,
  input  logic [XLEN-1:0]     pipe_wr_data_i,
  output logic                pipe_stall_o,
  input  logic                lu_valid_i,
  output logic                lu_ready_o,
  input  logic [REG_ID_W-1:0] lu_rd_id_i,
  input  logic [XLEN-1:0]     lu_wr_data_i,
  output logic [XLEN-1:0]     busy_mask_o,
  output logic                rf_wr_en_o,
  output logic [REG_ID_W-1:0] rf_wr_id_o,
  output logic [XLEN-1:0]     rf_wr_data_o
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

  logic                            full;
  logic                            empty;
  logic                            pop;
  lu_entry_t                       head;
  lu_entry_t                       push_entry;
  logic [DEPTH-1:0]                entry_vld;
  logic [DEPTH-1:0][REG_ID_W-1:0]  entry_rd;
  logic [WW-1:0]                   wait_cnt;
  logic                            head_live;
  logic                            head_zero;
  logic                            pipe_valid;
  logic                            conflict;
  logic                            fifo_go;
  logic [XLEN-1:0]                 busy_mask;
  wb_req_t                         grant;

  assign push_entry = '{rd_id: lu_rd_id_i, data: lu_wr_data_i};

  regfile_wr_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (lu_valid_i && !rst),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .head       (head),
    .entry_vld  (entry_vld),
    .entry_rd   (entry_rd)
  );

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i]) busy_mask[entry_rd[i]] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

  assign head_live  = !rst && !empty && (head.rd_id != '0);
  assign head_zero  = !rst && !empty && (head.rd_id == '0);
  assign pipe_valid = !rst && pipe_wr_en_i && (pipe_rd_id_i != '0);
  assign conflict   = pipe_valid && busy_mask[pipe_rd_id_i];
  assign fifo_go    = head_live && (!pipe_valid || conflict || wait_cnt == WAIT_LIMIT);
  // An rd=0 head is dropped in place so it never costs the pipeline a cycle.
  assign pop        = fifo_go || head_zero;

  always_comb begin
    grant        = '0;
    pipe_stall_o = 1'b0;
    if (fifo_go) begin
      grant        = '{en: 1'b1, rd_id: head.rd_id, data: head.data};
      pipe_stall_o = pipe_valid;
    end else if (pipe_valid) begin
      grant = '{en: 1'b1, rd_id: pipe_rd_id_i, data: pipe_wr_data_i};
    end
  end

  assign rf_wr_en_o   = grant.en;
  assign rf_wr_id_o   = grant.rd_id;
  assign rf_wr_data_o = grant.data;
  assign lu_ready_o   = !full;
  assign busy_mask_o  = busy_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (pop) begin
      wait_cnt <= '0;
    end else if (head_live && !fifo_go && wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with hand-computed expectations.
module tb_regfile_wr_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_wr_en_i;
  logic [4:0]  pipe_rd_id_i;
  logic [31:0] pipe_wr_data_i;
  logic        pipe_stall_o;
  logic        lu_valid_i;
  logic        lu_ready_o;
  logic [4:0]  lu_rd_id_i;
  logic [31:0] lu_wr_data_i;
  logic [31:0] busy_mask_o;
  logic        rf_wr_en_o;
  logic [4:0]  rf_wr_id_o;
  logic [31:0] rf_wr_data_o;

  int checks = 0;
  int errors = 0;

  regfile_wr_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .pipe_wr_en_i   (pipe_wr_en_i),
    .pipe_rd_id_i   (pipe_rd_id_i),
    .pipe_wr_data_i (pipe_wr_data_i),
    .pipe_stall_o   (pipe_stall_o),
    .lu_valid_i     (lu_valid_i),
    .lu_ready_o     (lu_ready_o),
    .lu_rd_id_i     (lu_rd_id_i),
    .lu_wr_data_i   (lu_wr_data_i),
    .busy_mask_o    (busy_mask_o),
    .rf_wr_en_o     (rf_wr_en_o),
    .rf_wr_id_o     (rf_wr_id_o),
    .rf_wr_data_o   (rf_wr_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pipe(input logic en, input logic [4:0] rd, input logic [31:0] d);
    pipe_wr_en_i = en; pipe_rd_id_i = rd; pipe_wr_data_i = d;
  endtask

  task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lu_valid_i = v; lu_rd_id_i = rd; lu_wr_data_i = d;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [4:0] id,
                        input logic [31:0] d, input logic stall);
    chk({tag, "_en"},    32'(rf_wr_en_o),   32'(en));
    chk({tag, "_id"},    32'(rf_wr_id_o),   32'(id));
    chk({tag, "_data"},  rf_wr_data_o,      d);
    chk({tag, "_stall"}, 32'(pipe_stall_o), 32'(stall));
  endtask

  initial begin
    rst = 1'b1;
    pipe(1'b1, 5'd3, 32'h3333);
    lu(1'b0, 5'd0, 32'h0);
    #2;
    chk_wr("rst_out", 1'b0, 5'd0, 32'h0, 1'b0);
    chk("rst_ready", 32'(lu_ready_o), 32'd1);
    chk("rst_busy", busy_mask_o, 32'h0);

    tick();
    rst = 1'b0;
    pipe(1'b0, 5'd0, 32'h0);

    // Idle pipeline, single long-latency result, no bypass.
    tick();
    lu(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("t1_nobypass", 32'(rf_wr_en_o), 32'd0);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    #1;
    chk_wr("t1_wr", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    chk("t1_busy_c1", busy_mask_o, 32'h0000_0020);
    tick();
    #1;
    chk("t1_busy_c2", busy_mask_o, 32'h0);
    chk("t1_idle", 32'(rf_wr_en_o), 32'd0);

    // Starvation bound: pipeline keeps the port for MAX_WAIT cycles, then yields one.
    tick();
    pipe(1'b1, 5'd3, 32'h33);
    lu(1'b1, 5'd7, 32'h77);
    #1;
    chk_wr("t2_c0", 1'b1, 5'd3, 32'h33, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      lu(1'b0, 5'd0, 32'h0);
      #1;
      chk_wr($sformatf("t2_c%0d", c), 1'b1, 5'd3, 32'h33, 1'b0);
    end
    chk("t2_busy", busy_mask_o, 32'h0000_0080);
    tick();
    #1;
    chk_wr("t2_c5", 1'b1, 5'd7, 32'h77, 1'b1);
    tick();
    #1;
    chk_wr("t2_c6", 1'b1, 5'd3, 32'h33, 1'b0);
    chk("t2_busy_clr", busy_mask_o, 32'h0);

    // WAW: pipeline targets a register still owned by a buffered result.
    tick();
    lu(1'b1, 5'd9, 32'h99);
    #1;
    chk_wr("t3_a", 1'b1, 5'd3, 32'h33, 1'b0);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    pipe(1'b1, 5'd9, 32'h1234);
    #1;
    chk_wr("t3_b", 1'b1, 5'd9, 32'h99, 1'b1);
    tick();
    #1;
    chk_wr("t3_c", 1'b1, 5'd9, 32'h1234, 1'b0);

    // Full FIFO: third result waits, and a pop does not open the port for a push that cycle.
    tick();
    pipe(1'b1, 5'd1, 32'h11);
    lu(1'b1, 5'd10, 32'hA0);
    #1;
    chk("t4_c0_ready", 32'(lu_ready_o), 32'd1);
    tick();
    lu(1'b1, 5'd11, 32'hB0);
    #1;
    chk("t4_c1_ready", 32'(lu_ready_o), 32'd1);
    tick();
    lu(1'b1, 5'd12, 32'hC0);
    #1;
    chk("t4_c2_ready", 32'(lu_ready_o), 32'd0);
    chk("t4_c2_busy", busy_mask_o, 32'h0000_0C00);
    chk_wr("t4_c2", 1'b1, 5'd1, 32'h11, 1'b0);
    tick(); tick(); tick();
    #1;
    chk_wr("t4_c5", 1'b1, 5'd10, 32'hA0, 1'b1);
    chk("t4_c5_ready", 32'(lu_ready_o), 32'd0);
    chk("t4_c5_busy", busy_mask_o, 32'h0000_0C00);
    tick();
    #1;
    chk("t4_c6_ready", 32'(lu_ready_o), 32'd1);
    chk_wr("t4_c6", 1'b1, 5'd1, 32'h11, 1'b0);
    chk("t4_c6_busy", busy_mask_o, 32'h0000_0800);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    #1;
    chk("t4_c7_busy", busy_mask_o, 32'h0000_1800);
    tick(); tick(); tick();
    #1;
    chk_wr("t4_c10", 1'b1, 5'd11, 32'hB0, 1'b1);
    for (int c = 11; c <= 14; c++) begin
      tick();
      #1;
      chk_wr($sformatf("t4_c%0d", c), 1'b1, 5'd1, 32'h11, 1'b0);
    end
    tick();
    #1;
    chk_wr("t4_c15", 1'b1, 5'd12, 32'hC0, 1'b1);
    tick();
    #1;
    chk("t4_busy_end", busy_mask_o, 32'h0);

    // rd=0 on either side never writes and never stalls.
    pipe(1'b0, 5'd0, 32'h0);
    lu(1'b1, 5'd0, 32'h55);
    #1;
    chk("t5_push", 32'(rf_wr_en_o), 32'd0);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    pipe(1'b1, 5'd3, 32'h3A);
    #1;
    chk_wr("t5_zero_head", 1'b1, 5'd3, 32'h3A, 1'b0);
    tick();
    pipe(1'b1, 5'd0, 32'hBAD);
    #1;
    chk_wr("t5_pipe_zero", 1'b0, 5'd0, 32'h0, 1'b0);
    chk("t5_ready", 32'(lu_ready_o), 32'd1);
    chk("t5_busy", busy_mask_o, 32'h0);

    // Mid-cycle reset with two buffered entries.
    tick();
    pipe(1'b1, 5'd2, 32'h22);
    lu(1'b1, 5'd20, 32'h2000);
    tick();
    lu(1'b1, 5'd21, 32'h2100);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    #1;
    chk("t6_busy_pre", busy_mask_o, 32'h0030_0000);
    chk("t6_ready_pre", 32'(lu_ready_o), 32'd0);
    rst = 1'b1;
    #1;
    chk_wr("t6_rst", 1'b0, 5'd0, 32'h0, 1'b0);
    chk("t6_rst_ready", 32'(lu_ready_o), 32'd1);
    chk("t6_rst_busy", busy_mask_o, 32'h0);
    tick();
    rst = 1'b0;
    pipe(1'b0, 5'd0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("t6_nostale_%0d", c), 32'(rf_wr_en_o), 32'd0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
